// File: rtl/rpn_evaluator.sv
// rpn_evaluator: postfix (RPN) expression evaluator for the calculator CPU.
//
// Consumes the operand/operator token stream produced by the infix-to-postfix stage, keeps an
// operand stack and returns exactly one result (or error code) per expression.
//
// Optional feature: define RPN_DIV_EN to build the iterative divider (DIV state) so that the
// `CO_DI operator is supported. Without it `CO_DI is an illegal operator (res_err[2]).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   token handshake; in_ready is high only while accepting tokens
//   in_is_op              1 = operator token (in_op), 0 = operand token (in_data)
//   in_op                 operator code (`CO_AD/`CO_SB/`CO_MU/`CO_DI, others illegal)
//   in_data               signed operand value
//   in_last               marks the final token of the expression
//   res_valid / res_ready result handshake; res_* held stable until consumed
//   res_data              result, 0 when any error bit is set
//   res_err               [0] stack overflow, [1] underflow/malformed, [2] div-by-0/illegal op
`timescale 1ns/1ps

// Operator encoding normally comes from CPU_INTERNAL.v; fall back to matching defaults.
`ifndef CO_N
`define CO_N 3
`endif
`ifndef CO_AD
`define CO_AD 3'd0
`endif
`ifndef CO_SB
`define CO_SB 3'd1
`endif
`ifndef CO_MU
`define CO_MU 3'd2
`endif
`ifndef CO_DI
`define CO_DI 3'd3
`endif
`ifndef CO_LP
`define CO_LP 3'd4
`endif
`ifndef CO_RP
`define CO_RP 3'd5
`endif

module rpn_evaluator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_op,
    input  logic [`CO_N-1:0]  in_op,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic [2:0]        res_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntTwo  = CW'(2);

`ifdef RPN_DIV_EN
    localparam int unsigned DcW = $clog2(WIDTH + 1);
    localparam logic [DcW-1:0] DivSteps = DcW'(WIDTH);

    typedef enum logic [1:0] {StAccept, StDiv, StDone} state_e;
`else
    typedef enum logic [1:0] {StAccept, StDone} state_e;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   stack_q [DEPTH];
    logic [WIDTH-1:0]   stack_d [DEPTH];
    logic [CW-1:0]      count_q, count_d;
    logic [2:0]         err_q, err_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;

    logic [IW-1:0]      top_idx, sec_idx, push_idx;
    logic [WIDTH-1:0]   op_a, op_b, alu_res;
    logic               finish;

`ifdef RPN_DIV_EN
    // Divider: quotient register starts as |a| and shifts in quotient bits from the right.
    logic [WIDTH-1:0]   div_quo_q, div_quo_d;
    logic [WIDTH-1:0]   div_b_q, div_b_d;
    logic [WIDTH-1:0]   div_rem_q, div_rem_d;
    logic [DcW-1:0]     div_cnt_q, div_cnt_d;
    logic               div_neg_q, div_neg_d;
    logic               div_last_q, div_last_d;
    logic [WIDTH:0]     rem_shift;
    logic               div_geq;
`endif

    assign top_idx  = IW'(count_q - CntOne);
    assign sec_idx  = IW'(count_q - CntTwo);
    assign push_idx = IW'(count_q);
    assign op_a     = stack_q[sec_idx];
    assign op_b     = stack_q[top_idx];

    assign in_ready  = (state_q == StAccept);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_valid_q ? err_q : 3'b000;

    always_comb begin
        alu_res = op_a * op_b;
        case (in_op)
            `CO_AD:  alu_res = op_a + op_b;
            `CO_SB:  alu_res = op_a - op_b;
            default: alu_res = op_a * op_b;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        stack_d     = stack_q;
        count_d     = count_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        finish      = 1'b0;
`ifdef RPN_DIV_EN
        div_quo_d  = div_quo_q;
        div_b_d    = div_b_q;
        div_rem_d  = div_rem_q;
        div_cnt_d  = div_cnt_q;
        div_neg_d  = div_neg_q;
        div_last_d = div_last_q;
        rem_shift  = {div_rem_q, div_quo_q[WIDTH-1]};
        div_geq    = (rem_shift >= {1'b0, div_b_q});
`endif

        unique case (state_q)
            StAccept: begin
                if (in_valid) begin
                    // A pending error turns every token into a no-op until in_last.
                    if (err_q == 3'b000) begin
                        if (!in_is_op) begin
                            if (count_q == CntFull) begin
                                err_d[0] = 1'b1;
                            end else begin
                                stack_d[push_idx] = in_data;
                                count_d           = count_q + CntOne;
                            end
                        end else begin
                            case (in_op)
                                `CO_AD, `CO_SB, `CO_MU: begin
                                    if (count_q < CntTwo) begin
                                        err_d[1] = 1'b1;
                                    end else begin
                                        stack_d[sec_idx] = alu_res;
                                        count_d          = count_q - CntOne;
                                    end
                                end
`ifdef RPN_DIV_EN
                                `CO_DI: begin
                                    if (count_q < CntTwo) begin
                                        err_d[1] = 1'b1;
                                    end else begin
                                        // Both operands leave the stack now; quotient is
                                        // pushed back when the divide finishes.
                                        count_d    = count_q - CntTwo;
                                        state_d    = StDiv;
                                        div_quo_d  = op_a[WIDTH-1] ? -op_a : op_a;
                                        div_b_d    = op_b[WIDTH-1] ? -op_b : op_b;
                                        div_rem_d  = '0;
                                        div_cnt_d  = '0;
                                        div_neg_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                                        div_last_d = in_last;
                                    end
                                end
`endif
                                default: err_d[2] = 1'b1;
                            endcase
                        end
                    end
                    // A divide carrying in_last finishes from the DIV state instead.
                    if (in_last && state_d == StAccept) begin
                        finish = 1'b1;
                    end
                end
            end
`ifdef RPN_DIV_EN
            StDiv: begin
                if (div_b_q == '0) begin
                    err_d[2] = 1'b1;
                    state_d  = StAccept;
                    finish   = div_last_q;
                end else if (div_cnt_q != DivSteps) begin
                    div_rem_d = div_geq ? WIDTH'(rem_shift - {1'b0, div_b_q})
                                        : rem_shift[WIDTH-1:0];
                    div_quo_d = {div_quo_q[WIDTH-2:0], div_geq};
                    div_cnt_d = div_cnt_q + DcW'(1);
                end else begin
                    // Negating the magnitude quotient truncates toward zero; MIN/-1 wraps.
                    stack_d[push_idx] = div_neg_q ? -div_quo_q : div_quo_q;
                    count_d           = count_q + CntOne;
                    state_d           = StAccept;
                    finish            = div_last_q;
                end
            end
`endif
            StDone: begin
                if (res_ready) begin
                    count_d     = '0;
                    err_d       = 3'b000;
                    res_valid_d = 1'b0;
                    res_data_d  = '0;
                    state_d     = StAccept;
                end
            end
            default: state_d = StAccept;
        endcase

        // End of expression: a clean run must leave exactly one value on the stack.
        if (finish) begin
            if (err_d == 3'b000 && count_d != CntOne) begin
                err_d[1] = 1'b1;
            end
            state_d     = StDone;
            res_valid_d = 1'b1;
            res_data_d  = (err_d == 3'b000) ? stack_d[0] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAccept;
            count_q     <= '0;
            err_q       <= 3'b000;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
`ifdef RPN_DIV_EN
            div_quo_q  <= '0;
            div_b_q    <= '0;
            div_rem_q  <= '0;
            div_cnt_q  <= '0;
            div_neg_q  <= 1'b0;
            div_last_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            stack_q     <= stack_d;
`ifdef RPN_DIV_EN
            div_quo_q  <= div_quo_d;
            div_b_q    <= div_b_d;
            div_rem_q  <= div_rem_d;
            div_cnt_q  <= div_cnt_d;
            div_neg_q  <= div_neg_d;
            div_last_q <= div_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_rpn_evaluator.sv
// tb_rpn_evaluator: self-checking bench for rpn_evaluator (WIDTH=16, DEPTH=8).
// Expression vectors are kept in a table; expected results go to a scoreboard queue when the
// final token is driven and are compared when the DUT completes the result handshake.
`timescale 1ns/1ps

`ifndef CO_N
`define CO_N 3
`endif
`ifndef CO_AD
`define CO_AD 3'd0
`endif
`ifndef CO_SB
`define CO_SB 3'd1
`endif
`ifndef CO_MU
`define CO_MU 3'd2
`endif
`ifndef CO_DI
`define CO_DI 3'd3
`endif
`ifndef CO_LP
`define CO_LP 3'd4
`endif
`ifndef CO_RP
`define CO_RP 3'd5
`endif

module tb_rpn_evaluator;

    localparam int W = 16;
    localparam int D = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_is_op = 1'b0;
    logic [`CO_N-1:0]  in_op = '0;
    logic [W-1:0]      in_data = '0;
    logic              in_last = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [W-1:0]      res_data;
    logic [2:0]        res_err;

    rpn_evaluator #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_is_op  (in_is_op),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             is_op;
        logic [`CO_N-1:0] op;
        logic [15:0]      data;
    } tok_t;

    typedef struct {
        int          ntok;
        tok_t        tok [16];
        logic [15:0] data;
        logic [2:0]  err;
        int          lat;    // cycles from last-token acceptance+1 until res_valid
        int          stall;  // in_ready-low cycles seen while presenting tokens
    } vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  err;
    } res_t;

    vec_t  vecs[$];
    vec_t  cur;
    res_t  exp_q[$];
    res_t  mon_e;
    int    n_checks = 0;
    int    n_fail = 0;
    int    stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic t_d(input logic [15:0] v);
        cur.tok[cur.ntok] = {1'b0, {`CO_N{1'b0}}, v};
        cur.ntok++;
    endtask

    task automatic t_o(input logic [`CO_N-1:0] op);
        cur.tok[cur.ntok] = {1'b1, op, 16'h0000};
        cur.ntok++;
    endtask

    task automatic commit(input logic [15:0] data, input logic [2:0] err, input int lat,
                          input int stall);
        cur.data  = data;
        cur.err   = err;
        cur.lat   = lat;
        cur.stall = stall;
        vecs.push_back(cur);
        cur.ntok = 0;
    endtask

    task automatic send(input tok_t t, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_is_op = t.is_op;
        in_op    = t.op;
        in_data  = t.data;
        in_last  = last;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        stalls += n;
        if (!in_ready) check("in_ready timeout", 32'(in_ready), 32'd1);
        tick();
    endtask

    task automatic wait_result(input string name, input int lat);
        int n = 0;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(lat));
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            check({name, " result timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        stalls = 0;
        for (int t = 0; t < v.ntok; t++) begin
            if (t == v.ntok - 1) exp_q.push_back({v.data, v.err});
            send(v.tok[t], t == v.ntok - 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check($sformatf("vec%0d stall", i), 32'(stalls), 32'(v.stall));
        wait_result($sformatf("vec%0d", i), v.lat);
    endtask

    // Scoreboard: compare on each result handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious result: got data 0x%0h err %b, none expected",
                         res_data, res_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("result data", 32'(res_data), 32'(mon_e.data));
                check("result err", 32'(res_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cur.ntok = 0;
        t_d(16'd3); t_d(16'd4); t_o(`CO_AD); t_d(16'd2); t_o(`CO_MU);
        commit(16'd14, 3'b000, 0, 0);
`ifdef RPN_DIV_EN
        t_d(16'hFFF9); t_d(16'd2); t_o(`CO_DI);            commit(16'hFFFD, 3'b000, 17, 0);
        t_d(16'h8000); t_d(16'hFFFF); t_o(`CO_DI);         commit(16'h8000, 3'b000, 17, 0);
        t_d(16'd7); t_d(16'hFFFE); t_o(`CO_DI);            commit(16'hFFFD, 3'b000, 17, 0);
        t_d(16'hFFF8); t_d(16'hFFFE); t_o(`CO_DI);         commit(16'd4, 3'b000, 17, 0);
        t_d(16'd100); t_d(16'd7); t_o(`CO_DI); t_d(16'd2); t_o(`CO_AD);
        commit(16'd16, 3'b000, 0, 17);
        t_d(16'd5); t_o(`CO_DI);                           commit(16'd0, 3'b010, 0, 0);
        t_d(16'd9); t_d(16'd0); t_o(`CO_DI);               commit(16'd0, 3'b100, 1, 0);
`else
        t_d(16'hFFF9); t_d(16'd2); t_o(`CO_DI);            commit(16'd0, 3'b100, 0, 0);
        t_d(16'd100); t_d(16'd7); t_o(`CO_DI); t_d(16'd2); t_o(`CO_AD);
        commit(16'd0, 3'b100, 0, 0);
        t_d(16'd5); t_o(`CO_DI);                           commit(16'd0, 3'b100, 0, 0);
        t_d(16'd9); t_d(16'd0); t_o(`CO_DI);               commit(16'd0, 3'b100, 0, 0);
`endif
        t_d(16'd1); t_d(16'd1); t_o(`CO_AD);               commit(16'd2, 3'b000, 0, 0);
        t_d(16'd5); t_o(`CO_AD);                           commit(16'd0, 3'b010, 0, 0);
        t_d(16'd1); t_d(16'd2);                            commit(16'd0, 3'b010, 0, 0);
        t_d(16'd10); t_d(16'd3); t_o(`CO_SB);              commit(16'd7, 3'b000, 0, 0);
        t_d(16'h7FFF); t_d(16'd1); t_o(`CO_AD);            commit(16'h8000, 3'b000, 0, 0);
        t_d(16'd300); t_d(16'd300); t_o(`CO_MU);           commit(16'h5F90, 3'b000, 0, 0);
        t_d(16'hFFFF); t_d(16'hFFFF); t_o(`CO_MU);         commit(16'd1, 3'b000, 0, 0);
        t_d(16'd2); t_d(16'd3); t_o(`CO_SB);               commit(16'hFFFF, 3'b000, 0, 0);
        t_o(`CO_LP);                                       commit(16'd0, 3'b100, 0, 0);
        t_d(16'd5); t_o(`CO_RP); t_d(16'd1); t_o(`CO_AD);  commit(16'd0, 3'b100, 0, 0);
        t_d(16'd7); t_o(3'd7);                             commit(16'd0, 3'b100, 0, 0);
        t_d(16'd42);                                       commit(16'd42, 3'b000, 0, 0);
        // Stack exactly full, then folded back down.
        for (int k = 1; k <= D; k++) t_d(16'(k));
        for (int k = 1; k < D; k++) t_o(`CO_AD);
        commit(16'd36, 3'b000, 0, 0);

        // Reset state.
        repeat (3) tick();
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset res_data", 32'(res_data), 32'd0);
        check("reset res_err", 32'(res_err), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // Overflow with the result held while res_ready is low.
        res_ready = 1'b0;
        for (int k = 1; k <= D + 1; k++) send({1'b0, {`CO_N{1'b0}}, 16'(k)}, 1'b0);
        send({1'b1, `CO_AD, 16'h0}, 1'b0);
        exp_q.push_back({16'd0, 3'b001});
        send({1'b1, `CO_AD, 16'h0}, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("ovf valid next cycle", 32'(res_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("ovf hold valid", 32'(res_valid), 32'd1);
            check("ovf hold data", 32'(res_data), 32'd0);
            check("ovf hold err", 32'(res_err), 32'b001);
            check("ovf hold in_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        wait_result("ovf", 0);

        // Reset in the middle of an expression (mid-divide when the divider exists).
        send({1'b0, {`CO_N{1'b0}}, 16'd100}, 1'b0);
`ifdef RPN_DIV_EN
        send({1'b0, {`CO_N{1'b0}}, 16'd7}, 1'b0);
        send({1'b1, `CO_DI, 16'h0}, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (4) tick();
        check("mid-div in_ready", 32'(in_ready), 32'd0);
`else
        send({1'b0, {`CO_N{1'b0}}, 16'd7}, 1'b0);
        in_valid = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst res_valid", 32'(res_valid), 32'd0);
        check("midrst res_data", 32'(res_data), 32'd0);
        check("midrst res_err", 32'(res_err), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (25) tick();
        check("midrst no result", 32'(res_valid), 32'd0);
        t_d(16'd6); t_d(16'd3); t_o(`CO_SB);
        commit(16'd3, 3'b000, 0, 0);
        run_vec(vecs.size() - 1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
